// File: rtl/mmio_uart_ctrl.sv
// Memory-map decoder between the core data port, data RAM and NUM_CH UART channels.
// Optional MMIO_UART_IRQ_EN adds a per-channel IRQ_MASK register and registered irq output.
module mmio_uart_ctrl #(
    parameter int unsigned                DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0]      BASE_ADDR  = 32'h10010024,
    parameter int unsigned                NUM_CH     = 2,
    parameter int unsigned                CH_STRIDE  = 32'h20,
    parameter int unsigned                RX_DEPTH   = 4,
    parameter int unsigned                UART_W     = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_WIDTH-1:0]         Address,
    input  logic [DATA_WIDTH-1:0]         WriteData_in,
    input  logic                          MemWrite,
    output logic [DATA_WIDTH-1:0]         ReadData,
    output logic [DATA_WIDTH-1:0]         RAM_Address,
    output logic [DATA_WIDTH-1:0]         WriteData_out,
    output logic                          RAM_MemWrite,
    input  logic [DATA_WIDTH-1:0]         RAM_ReadData,
    output logic [NUM_CH-1:0]             tx_start,
    output logic [NUM_CH*UART_W-1:0]      tx_data,
    input  logic [NUM_CH-1:0]             tx_busy,
    input  logic [NUM_CH-1:0]             rx_valid,
    input  logic [NUM_CH*UART_W-1:0]      rx_data
`ifdef MMIO_UART_IRQ_EN
    ,
    output logic [NUM_CH-1:0]             irq
`endif
);
    localparam int unsigned PW = $clog2(RX_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [DATA_WIDTH-1:0] WIN        = DATA_WIDTH'(NUM_CH * CH_STRIDE);
    localparam logic [DATA_WIDTH-1:0] STRIDE     = DATA_WIDTH'(CH_STRIDE);
    localparam logic [DATA_WIDTH-1:0] OFF_TX_CTRL = 'h00;
    localparam logic [DATA_WIDTH-1:0] OFF_TX_DATA = 'h04;
    localparam logic [DATA_WIDTH-1:0] OFF_RX_STAT = 'h08;
    localparam logic [DATA_WIDTH-1:0] OFF_RX_DATA = 'h0C;
    localparam logic [DATA_WIDTH-1:0] OFF_RX_POP  = 'h10;
`ifdef MMIO_UART_IRQ_EN
    localparam logic [DATA_WIDTH-1:0] OFF_IRQ_MSK = 'h14;
`endif

    logic [DATA_WIDTH-1:0] rel;
    logic                  periph_hit;
    logic [DATA_WIDTH-1:0] ch_rdata [NUM_CH];

    // rel wraps to a huge value below BASE_ADDR, so one compare bounds both ends
    assign rel        = Address - BASE_ADDR;
    assign periph_hit = rel < WIN;

    assign RAM_Address   = periph_hit ? '0 : Address;
    assign RAM_MemWrite  = MemWrite & ~periph_hit;
    assign WriteData_out = WriteData_in;

    always_comb begin
        ReadData = '0;
        if (periph_hit) begin
            for (int c = 0; c < int'(NUM_CH); c++)
                ReadData = ReadData | ch_rdata[c];
        end else begin
            ReadData = RAM_ReadData;
        end
    end

    generate
        for (genvar gi = 0; gi < int'(NUM_CH); gi++) begin : gen_ch
            localparam logic [DATA_WIDTH-1:0] LO = DATA_WIDTH'(gi * CH_STRIDE);

            logic [DATA_WIDTH-1:0] loc;
            logic [DATA_WIDTH-1:0] off;
            logic                  sel;
            logic                  wr;
            logic                  tx_start_reg;
            logic                  pending_reg;
            logic [UART_W-1:0]     tx_data_reg;
            logic [UART_W-1:0]     fifo_mem [RX_DEPTH];
            logic [PW-1:0]         wr_ptr_reg;
            logic [PW-1:0]         rd_ptr_reg;
            logic [CW-1:0]         count_reg;
            logic                  overflow_reg;
            logic                  not_empty;
            logic                  full;
            logic                  push;
            logic                  pop_req;
            logic                  push_ok;
            logic                  pop_ok;
            logic [CW-1:0]         count_next;
            logic [DATA_WIDTH-1:0] status;

            assign loc = rel - LO;
            assign off = loc & ~DATA_WIDTH'(3);
            assign sel = periph_hit && (loc < STRIDE);
            assign wr  = sel & MemWrite;

            assign not_empty = (count_reg != '0);
            assign full      = (count_reg == CW'(RX_DEPTH));
            assign push      = rx_valid[gi];
            assign pop_req   = wr && (off == OFF_RX_POP);
            // A pop frees the slot a full-FIFO push needs, so both proceed together
            assign pop_ok    = pop_req & not_empty;
            assign push_ok   = push & (~full | pop_req);

            always_comb begin
                count_next = count_reg;
                if (push_ok & ~pop_ok)
                    count_next = count_reg + CW'(1);
                else if (pop_ok & ~push_ok)
                    count_next = count_reg - CW'(1);
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    tx_start_reg <= 1'b0;
                    pending_reg  <= 1'b0;
                    tx_data_reg  <= '0;
                    wr_ptr_reg   <= '0;
                    rd_ptr_reg   <= '0;
                    count_reg    <= '0;
                    overflow_reg <= 1'b0;
                end else begin
                    tx_start_reg <= 1'b0;
                    if (pending_reg) begin
                        if (!tx_busy[gi]) begin
                            tx_start_reg <= 1'b1;
                            pending_reg  <= 1'b0;
                        end
                    end else if (wr && (off == OFF_TX_CTRL) && WriteData_in[0]) begin
                        if (tx_busy[gi])
                            pending_reg  <= 1'b1;
                        else
                            tx_start_reg <= 1'b1;
                    end
                    if (wr && (off == OFF_TX_DATA))
                        tx_data_reg <= WriteData_in[UART_W-1:0];
                    if (push_ok)
                        wr_ptr_reg <= wr_ptr_reg + PW'(1);
                    if (pop_ok)
                        rd_ptr_reg <= rd_ptr_reg + PW'(1);
                    count_reg <= count_next;
                    if (pop_req && WriteData_in[1])
                        overflow_reg <= 1'b0;
                    else if (push && full && !pop_req)
                        overflow_reg <= 1'b1;
                end
            end

            always_ff @(posedge clk) begin
                if (push_ok && !reset)
                    fifo_mem[wr_ptr_reg] <= rx_data[gi*UART_W +: UART_W];
            end

`ifdef MMIO_UART_IRQ_EN
            logic [1:0] mask_reg;
            logic       irq_reg;
            always_ff @(posedge clk) begin
                if (reset) begin
                    mask_reg <= '0;
                    irq_reg  <= 1'b0;
                end else begin
                    if (wr && (off == OFF_IRQ_MSK))
                        mask_reg <= WriteData_in[1:0];
                    irq_reg <= (mask_reg[0] & not_empty) | (mask_reg[1] & overflow_reg);
                end
            end
            assign irq[gi] = irq_reg;
`endif

            always_comb begin
                status       = '0;
                status[0]    = not_empty;
                status[1]    = overflow_reg;
                status[8 +: CW] = count_reg;
            end

            always_comb begin
                ch_rdata[gi] = '0;
                if (sel) begin
                    case (off)
                        OFF_TX_CTRL: ch_rdata[gi] = DATA_WIDTH'({tx_busy[gi], pending_reg});
                        OFF_TX_DATA: ch_rdata[gi] = DATA_WIDTH'(tx_data_reg);
                        OFF_RX_STAT: ch_rdata[gi] = status;
                        OFF_RX_DATA: ch_rdata[gi] = not_empty ? DATA_WIDTH'(fifo_mem[rd_ptr_reg]) : '0;
`ifdef MMIO_UART_IRQ_EN
                        OFF_IRQ_MSK: ch_rdata[gi] = DATA_WIDTH'(mask_reg);
`endif
                        default:     ch_rdata[gi] = '0;
                    endcase
                end
            end

            assign tx_start[gi]                  = tx_start_reg;
            assign tx_data[gi*UART_W +: UART_W]  = tx_data_reg;
        end
    endgenerate
endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Directed self-checking bench for mmio_uart_ctrl in its default build (two channels, 4-deep RX FIFO).
module tb_mmio_uart_ctrl;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] Address;
    logic [31:0] WriteData_in;
    logic        MemWrite;
    logic [31:0] ReadData;
    logic [31:0] RAM_Address;
    logic [31:0] WriteData_out;
    logic        RAM_MemWrite;
    logic [31:0] RAM_ReadData;
    logic [1:0]  tx_start;
    logic [15:0] tx_data;
    logic [1:0]  tx_busy;
    logic [1:0]  rx_valid;
    logic [15:0] rx_data;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] CH0_CTRL = 32'h10010024;
    localparam logic [31:0] CH0_DATA = 32'h10010028;
    localparam logic [31:0] CH0_STAT = 32'h1001002C;
    localparam logic [31:0] CH0_RXD  = 32'h10010030;
    localparam logic [31:0] CH0_POP  = 32'h10010034;
    localparam logic [31:0] CH0_UNIM = 32'h10010038;
    localparam logic [31:0] CH1_CTRL = 32'h10010044;
    localparam logic [31:0] CH1_DATA = 32'h10010048;

    mmio_uart_ctrl dut (
        .clk(clk), .reset(reset), .Address(Address), .WriteData_in(WriteData_in),
        .MemWrite(MemWrite), .ReadData(ReadData), .RAM_Address(RAM_Address),
        .WriteData_out(WriteData_out), .RAM_MemWrite(RAM_MemWrite),
        .RAM_ReadData(RAM_ReadData), .tx_start(tx_start), .tx_data(tx_data),
        .tx_busy(tx_busy), .rx_valid(rx_valid), .rx_data(rx_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("check %-14s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        Address = a; WriteData_in = d; MemWrite = 1'b1;
        step();
        MemWrite = 1'b0; Address = 32'h0;
    endtask

    task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
        Address = a; MemWrite = 1'b0;
        #1;
        chk(tag, ReadData, exp);
        Address = 32'h0;
    endtask

    task automatic rx_push0(input logic [7:0] v);
        rx_data = {8'h00, v}; rx_valid = 2'b01;
        step();
        rx_valid = 2'b00;
    endtask

    initial begin
        reset = 1'b1; Address = '0; WriteData_in = '0; MemWrite = 1'b0;
        RAM_ReadData = 32'hCAFEF00D; tx_busy = 2'b00; rx_valid = 2'b00; rx_data = '0;
        step(); step();
        reset = 1'b0;

        // Reset state
        chk("rst_tx_start", 32'(tx_start), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        bus_read("rst_tx_ctrl", CH0_CTRL, 32'h0);
        bus_read("rst_rx_stat", CH0_STAT, 32'h0);

        // RAM passthrough and window boundaries
        Address = 32'h10010000; WriteData_in = 32'hDEADBEEF; MemWrite = 1'b1;
        #1;
        chk("ram_we", 32'(RAM_MemWrite), 32'h1);
        chk("ram_addr", RAM_Address, 32'h10010000);
        chk("ram_wdata", WriteData_out, 32'hDEADBEEF);
        chk("ram_rdata", ReadData, 32'hCAFEF00D);
        step();
        chk("ram_no_start", 32'(tx_start), 32'h0);
        Address = CH0_CTRL; WriteData_in = 32'h0; MemWrite = 1'b1;
        #1;
        chk("per_we", 32'(RAM_MemWrite), 32'h0);
        chk("per_addr", RAM_Address, 32'h0);
        Address = 32'h10010064;
        #1;
        chk("past_win_we", 32'(RAM_MemWrite), 32'h1);
        chk("past_win_addr", RAM_Address, 32'h10010064);
        Address = 32'h10010020;
        #1;
        chk("below_win_addr", RAM_Address, 32'h10010020);
        Address = CH0_UNIM;
        #1;
        chk("unimp_we", 32'(RAM_MemWrite), 32'h0);
        step();
        MemWrite = 1'b0;
        bus_read("unimp_rd", CH0_UNIM, 32'h0);

        // TX idle launch on channel 1
        bus_write(CH1_DATA, 32'h41);
        chk("ch1_txdata", 32'(tx_data[15:8]), 32'h41);
        bus_read("ch1_txdata_rd", CH1_DATA, 32'h41);
        bus_write(CH1_CTRL, 32'h1);
        chk("ch1_pulse", 32'(tx_start), 32'h2);
        step();
        chk("ch1_pulse_end", 32'(tx_start), 32'h0);

        // TX busy deferral on channel 0
        tx_busy = 2'b01;
        bus_write(CH0_CTRL, 32'h1);
        chk("busy_no_pulse", 32'(tx_start), 32'h0);
        bus_read("busy_pending", CH0_CTRL, 32'h3);
        bus_write(CH0_CTRL, 32'h1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("busy_hold", 32'(tx_start), 32'h0);
        end
        tx_busy = 2'b00;
        step();
        chk("deferred_pulse", 32'(tx_start), 32'h1);
        bus_read("pending_clr", CH0_CTRL, 32'h0);
        step();
        chk("deferred_end", 32'(tx_start), 32'h0);
        step();
        chk("no_second", 32'(tx_start), 32'h0);

        // RX fill beyond depth
        for (int i = 0; i < 5; i++) rx_push0(8'(8'h11 + i));
        bus_read("full_stat", CH0_STAT, 32'h0000_0403);
        bus_read("full_head", CH0_RXD, 32'h11);
        for (int i = 0; i < 4; i++) begin
            bus_read("pop_order", CH0_RXD, 32'(8'h11 + i));
            bus_write(CH0_POP, 32'h0);
        end
        bus_read("empty_stat", CH0_STAT, 32'h0000_0002);
        bus_read("empty_rxd", CH0_RXD, 32'h0);
        bus_write(CH0_POP, 32'h0);
        bus_read("pop_empty", CH0_STAT, 32'h0000_0002);
        bus_write(CH0_POP, 32'h2);
        bus_read("ovf_clear", CH0_STAT, 32'h0);

        // Simultaneous push and pop while full, then drain across the wrap
        for (int i = 0; i < 4; i++) rx_push0(8'(8'h21 + i));
        bus_read("refill_stat", CH0_STAT, 32'h0000_0401);
        rx_data = {8'h00, 8'h25}; rx_valid = 2'b01;
        bus_write(CH0_POP, 32'h0);
        rx_valid = 2'b00;
        bus_read("pushpop_stat", CH0_STAT, 32'h0000_0401);
        for (int i = 0; i < 4; i++) begin
            bus_read("wrap_order", CH0_RXD, 32'(8'h22 + i));
            bus_write(CH0_POP, 32'h0);
        end
        bus_read("drained", CH0_STAT, 32'h0);

        // Reset mid-operation
        for (int i = 0; i < 3; i++) rx_push0(8'(8'h31 + i));
        bus_read("pre_rst_stat", CH0_STAT, 32'h0000_0301);
        tx_busy = 2'b01;
        bus_write(CH0_CTRL, 32'h1);
        bus_read("pre_rst_pend", CH0_CTRL, 32'h3);
        tx_busy = 2'b00;
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus_read("rst_stat", CH0_STAT, 32'h0);
        bus_read("rst_pend", CH0_CTRL, 32'h0);
        chk("rst_start", 32'(tx_start), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_no_pulse", 32'(tx_start), 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
